// File: rtl/reg_scoreboard.sv
// reg_scoreboard: decode-stage issue control that tracks pending register writes and stalls on RAW/WAW/capacity.
// Writebacks bypass in the same cycle because the register file writes on the falling edge.
module reg_scoreboard #(
    parameter int MAX_PEND = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic [5:0]       id_rd,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic             id_wr_en,
    input  logic             wb_valid,
    input  logic [5:0]       wb_reg,
    input  logic             flush,
    output logic             id_ready,
    output logic             issue,
    output logic [31:0]      busy_mask,
    output logic [5:0]       pend_cnt,
    output logic             draining,
    output logic [CNT_W-1:0] stall_cycles,
    output logic             wb_err
);
    typedef enum logic {RUN, DRAIN} state_t;
    state_t           state_q;
    logic [31:0]      busy_q, busy_d, eff_busy, set_v, clr_v;
    logic [5:0]       cnt_q, cnt_d;
    logic [CNT_W-1:0] stall_q;
    logic             err_q, clr_hit, raw, waw, full, rd_ok;
    always_comb begin
        // busy_q[0] is never set, so register 0 can never produce a clear hit
        clr_hit  = wb_valid & ~wb_reg[5] & busy_q[wb_reg[4:0]];
        clr_v    = clr_hit ? 32'd1 << wb_reg[4:0] : 32'd0;
        eff_busy = busy_q & ~clr_v;
        rd_ok    = ~id_rd[5] & (id_rd[4:0] != 5'd0);
        raw      = (id_use_rs1 & eff_busy[id_rs1]) | (id_use_rs2 & eff_busy[id_rs2]);
        waw      = id_wr_en & ~id_rd[5] & eff_busy[id_rd[4:0]];
        full     = id_wr_en & (id_rd != 6'd0) & ((cnt_q - {5'd0, clr_hit}) >= 6'(MAX_PEND));
        id_ready = rst_n & (state_q == RUN) & ~flush & ~raw & ~waw & ~full;
        issue    = id_valid & id_ready;
        set_v    = (issue & id_wr_en & rd_ok) ? 32'd1 << id_rd[4:0] : 32'd0;
        busy_d   = (busy_q & ~clr_v) | set_v;
        cnt_d    = 6'($countones(busy_d));
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            busy_q  <= '0;
            cnt_q   <= '0;
            stall_q <= '0;
            err_q   <= 1'b0;
        end else begin
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            if (id_valid & ~id_ready & ~&stall_q) stall_q <= stall_q + CNT_W'(1);
            if (wb_valid & ~clr_hit) err_q <= 1'b1;
            if (state_q == RUN) state_q <= flush ? DRAIN : RUN;
            else state_q <= (~flush & (busy_d == 32'd0)) ? RUN : DRAIN;
        end
    end
    assign busy_mask    = busy_q;
    assign pend_cnt     = cnt_q;
    assign draining     = (state_q == DRAIN);
    assign stall_cycles = stall_q;
    assign wb_err       = err_q;
endmodule

// File: doc/reg_scoreboard.md
# reg_scoreboard

Issue controller for the decode stage and 64-bit register file. It tracks which architectural registers have an in-flight write and decides, each cycle, whether the instruction in decode may issue. It stalls on RAW and WAW hazards and on scoreboard capacity limits, and drains outstanding writes on a pipeline flush. It sits between fetch/decode and execute, and observes the writeback port (`regwr`/`wr_reg`) that writes the register file on the falling clock edge.

## Interface
- `MAX_PEND`, default 4: maximum simultaneously pending destination registers (1..31).
- `CNT_W`, default 16: width of the saturating stall-cycle counter.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `id_valid` in 1: decode holds a valid instruction.
- `id_rs1` in 5: source register 1 index.
- `id_rs2` in 5: source register 2 index.
- `id_rd` in 6: destination register; bit 5 is always 0 for legal writes.
- `id_use_rs1` in 1: instruction reads `id_rs1`.
- `id_use_rs2` in 1: instruction reads `id_rs2`.
- `id_wr_en` in 1: instruction writes `id_rd`.
- `wb_valid` in 1: writeback retires a write this cycle (same as register-file `regwr`).
- `wb_reg` in 6: writeback destination (same as register-file `wr_reg`).
- `flush` in 1: pipeline flush request, single- or multi-cycle.
- `id_ready` out 1: decode may issue (combinational).
- `issue` out 1: `id_valid & id_ready`.
- `busy_mask` out 32: bit n set means register n has a pending write (registered).
- `pend_cnt` out 6: popcount of `busy_mask` (registered).
- `draining` out 1: FSM is in DRAIN.
- `stall_cycles` out CNT_W: saturating count of cycles with `id_valid & ~id_ready`.
- `wb_err` out 1: sticky flag; a writeback targeted a non-pending register.

## Operation
- Registers are numbered 0..31; register 0 is never marked or cleared.
- Any 6-bit index with bit 5 set is ignored for marking and clearing.
- `clr_hit(r)` = `wb_valid & (wb_reg == r) & busy_mask[r]`.
- `eff_busy(r)` = `busy_mask[r] & ~clr_hit(r)`. This is a same-cycle bypass: the register file writes on the falling edge, so execute reads the new value.
- `raw` = (`id_use_rs1 & eff_busy(id_rs1)`) | (`id_use_rs2 & eff_busy(id_rs2)`).
- `waw` = `id_wr_en & eff_busy(id_rd)`.
- `full` = `id_wr_en & id_rd != 0` & (`pend_cnt - (any clr_hit)`) ≥ `MAX_PEND`.
- `id_ready` = `rst_n` & (state == RUN) & `~flush` & `~raw` & `~waw` & `~full`.
- On `issue` with `id_wr_en` and `id_rd` ∈ 1..31: set `busy_mask[id_rd]` next cycle.
- On `clr_hit`: clear that bit next cycle.
- If set and clear target the same register in the same cycle, set wins. Per the WAW rule this only occurs via the bypass, and the new write stays pending.
- `pend_cnt` is the registered popcount of the next mask. Set and clear in the same cycle on different registers leave it unchanged.
- `wb_valid` to a register with bit 0 in the mask, index 0, or bit 5 set: no mask change; `wb_err` is set until reset.
- FSM has two states, RUN and DRAIN.
  - RUN → DRAIN when `flush` = 1. No issue occurs in that cycle.
  - DRAIN: `id_ready` = 0 and no marks. Writebacks still clear bits.
  - DRAIN → RUN on the first edge where the next mask is all-zero and `flush` = 0.
  - `flush` held in DRAIN keeps the FSM in DRAIN.
- `stall_cycles` increments when `id_valid & ~id_ready` and saturates at all-ones. It does not wrap.

## Timing
- Reset (asynchronous, `rst_n` = 0): `busy_mask` = 0, `pend_cnt` = 0, state = RUN, `draining` = 0, `stall_cycles` = 0, `wb_err` = 0, `id_ready` = 0, `issue` = 0.
- A mark is visible in `busy_mask` one cycle after `issue`.
- A dependent instruction in decode the next cycle stalls until the cycle its producer's `wb_valid` appears. It issues in that same cycle, so there is zero bubble after writeback.
- Reset asserted mid-drain or mid-stall: all state clears immediately. The FSM returns to RUN with an empty mask, and pending writebacks arriving afterwards raise `wb_err`.
- `id_ready` depends combinationally on `id_*`, `wb_*`, `flush` and registered state only. There is no path from `issue` back to `id_ready`.

## Test plan
- Issue rd=5 at cycle 0, then rs1=5 from cycle 1; `wb_valid` with `wb_reg`=5 at cycle 4 → `id_ready` is 0 in cycles 1–3 and 1 in cycle 4, `busy_mask[5]` clears at cycle 5, `stall_cycles` = 3.
- Issue rd=0 and rd=6'h25 → `busy_mask` stays 0 and `pend_cnt` stays 0. `wb_valid` with `wb_reg`=0 → `wb_err` = 1.
- With `MAX_PEND`=4, issue rd=1,2,3,4 back to back, then a 5th writer rd=7 → stalls with `pend_cnt`=4. `wb_valid` on reg 2 → rd=7 issues in that cycle and `pend_cnt` stays 4.
- Same cycle: `wb_valid` on reg 9 and issue of rd=9 (reads rs1=9) → issues with no stall, `busy_mask[9]` = 1 next cycle.
- Pending {3,8}; `flush` for 2 cycles; writebacks on 3 then 8 at cycles 4 and 6 → `draining` = 1 and `id_ready` = 0 through cycle 6, RUN at cycle 7.
- Hold `id_valid` with rs1 pending for 70000 cycles using `CNT_W`=16 → `stall_cycles` saturates at 65535.
